char_buf_writer: RTL and testbench

//  Writable 16x16 text buffer: the fill side of the character grid the text renderer reads.

---
 rtl/char_buf_pkg.sv | 29 ++
 rtl/char_buf_ram.sv | 38 +++
 rtl/char_buf_writer.sv | 158 +++++++++++++++
 tb/tb_char_buf_writer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/char_buf_pkg.sv
// Shared constants for the writable 16x16 character buffer.
// Holds the grid geometry, the control-code values, the FSM state encodings
// and a small helper that classifies printable bytes.
package char_buf_pkg;

    localparam int COLS  = 16;
    localparam int ROWS  = 16;
    localparam int DEPTH = COLS * ROWS;

    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_BS     = 8'h08;
    localparam logic [7:0] CH_FF     = 8'h0C;
    localparam logic [7:0] PRINT_MIN = 8'h20;
    localparam logic [7:0] PRINT_MAX = 8'h7E;

    // Code left behind by a backspace (always a space, independent of CLEAR_CHAR)
    localparam logic [6:0] BLANK_CHAR = 7'h20;

    // FSM state encodings
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    // True for bytes that are stored at the cursor; bit 7 set is never printable
    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_MIN) && (c <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/char_buf_ram.sv
// 256 x 7 character storage: one synchronous write port and one registered
// read port. A read and a write to the same address in the same cycle return
// the old contents (read-before-write). Contents are not reset; the writer
// defines them by running its clear sequence after every reset.
module char_buf_ram
    import char_buf_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_we,
    input  logic [7:0] i_waddr,
    input  logic [6:0] i_wdata,
    input  logic [7:0] i_raddr,
    output logic [6:0] o_rdata
);

    logic [6:0] r_mem [0:DEPTH-1];
    logic [6:0] r_rdata;

    // Storage array write; no reset so this maps onto block RAM
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read, samples the array before this cycle's write lands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 7'h00;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/char_buf_writer.sv
// Fill side of the 16x16 text grid. Takes an ASCII byte stream (valid/ready),
// stores printable codes at a hardware cursor and handles CR, LF, BS and FF.
// The read port (char_xy -> char_code, one cycle latency) matches the fixed
// char ROM so the renderer can use this block as a drop-in text source.
// Optional feature macro CHAR_BUF_CURSOR_EN: blinking "_" overlay drawn at the
// cursor position, toggling every BLINK_DIV cycles.
module char_buf_writer
    import char_buf_pkg::*;
#(
    parameter logic [6:0] CLEAR_CHAR = 7'h20
`ifdef CHAR_BUF_CURSOR_EN
    ,
    parameter int BLINK_DIV = 2**24
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code,
    output logic [7:0] cursor_xy,
    output logic       busy
);

    logic [0:0] r_state;
    logic [7:0] r_clr_addr;
    logic [7:0] r_cursor;

    logic       w_accept;
    logic       w_we;
    logic [7:0] w_waddr;
    logic [6:0] w_wdata;
    logic [6:0] w_ram_rdata;

    assign w_accept = in_valid && (r_state == ST_IDLE);

    // Select the single RAM write for this cycle: clear sweep, printable or backspace blank
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_addr;
        w_wdata = CLEAR_CHAR;
        if (r_state == ST_CLEAR) begin
            w_we = 1'b1;
        end else if (w_accept) begin
            if (is_printable(in_char)) begin
                w_we    = 1'b1;
                w_waddr = r_cursor;
                w_wdata = in_char[6:0];
            end else if ((in_char == CH_BS) && (r_cursor[3:0] != 4'h0)) begin
                w_we    = 1'b1;
                w_waddr = {r_cursor[7:4], r_cursor[3:0] - 4'h1};
                w_wdata = BLANK_CHAR;
            end else begin
                w_we = 1'b0;
            end
        end else begin
            w_we = 1'b0;
        end
    end

    // Control FSM: 256-cycle clear sweep, then byte interpretation and cursor motion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_CLEAR;
            r_clr_addr <= 8'h00;
            r_cursor   <= 8'h00;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_addr <= r_clr_addr + 8'h01;
                    if (r_clr_addr == 8'hFF) begin
                        r_state  <= ST_IDLE;
                        r_cursor <= 8'h00;
                    end
                end
                ST_IDLE: begin
                    if (w_accept) begin
                        if (is_printable(in_char)) begin
                            r_cursor <= r_cursor + 8'h01;
                        end else begin
                            case (in_char)
                                CH_CR: r_cursor[3:0] <= 4'h0;
                                CH_LF: r_cursor      <= {r_cursor[7:4] + 4'h1, 4'h0};
                                CH_BS: begin
                                    if (r_cursor[3:0] != 4'h0) begin
                                        r_cursor[3:0] <= r_cursor[3:0] - 4'h1;
                                    end
                                end
                                CH_FF: begin
                                    r_state    <= ST_CLEAR;
                                    r_clr_addr <= 8'h00;
                                    r_cursor   <= 8'h00;
                                end
                                default: ; // unsupported control or bit7 set: discard
                            endcase
                        end
                    end
                end
                default: begin
                    r_state    <= ST_CLEAR;
                    r_clr_addr <= 8'h00;
                end
            endcase
        end
    end

    char_buf_ram u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (char_xy),
        .o_rdata (w_ram_rdata)
    );

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_CLEAR);
    assign cursor_xy = r_cursor;

`ifdef CHAR_BUF_CURSOR_EN
    localparam int         DIV_W        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [6:0] CURSOR_GLYPH = 7'h5F;

    logic [DIV_W-1:0] r_blink_cnt;
    logic             r_phase;
    logic             r_ovl;

    // Free-running blink divider, phase flips once per BLINK_DIV cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == DIV_W'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + DIV_W'(1);
        end
    end

    // Overlay decision registered alongside the RAM read so latency stays one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovl <= 1'b0;
        end else begin
            r_ovl <= (char_xy == r_cursor) && r_phase && (r_state == ST_IDLE);
        end
    end

    assign char_code = r_ovl ? CURSOR_GLYPH : w_ram_rdata;
`else
    assign char_code = w_ram_rdata;
`endif

endmodule

// File: tb/tb_char_buf_writer.sv
// Scoreboard bench for char_buf_writer. Drivers push expected read data and
// expected cursor positions into queues; a monitor on the falling edge pops
// and compares whenever a read or a byte acceptance has completed.
module tb_char_buf_writer;

    typedef struct {
        logic [7:0] addr;
        logic [6:0] code;
    } rd_exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_char = 8'h00;
    logic [7:0] char_xy = 8'h00;
    logic       in_ready;
    logic       busy;
    logic [6:0] char_code;
    logic [7:0] cursor_xy;

    logic       rd_req = 1'b0;
    logic [7:0] model_cur = 8'h00;
    rd_exp_t    q_rd [$];
    logic [7:0] q_cur [$];
    int         n_cmp = 0;
    int         n_err = 0;

`ifdef CHAR_BUF_CURSOR_EN
    char_buf_writer #(.BLINK_DIV(4)) dut (
`else
    char_buf_writer dut (
`endif
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_char   (in_char),
        .char_xy   (char_xy),
        .char_code (char_code),
        .cursor_xy (cursor_xy),
        .busy      (busy)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Monitor: compare completed reads/acceptances, then note what completes at the next edge
    initial begin : monitor
        logic    pend_rd;
        logic    pend_acc;
        rd_exp_t e;
        logic [7:0] ec;
        pend_rd  = 1'b0;
        pend_acc = 1'b0;
        forever begin
            @(negedge clk);
            if (pend_rd) begin
                if (q_rd.size() == 0) begin
                    chk("rd_queue_empty", 32'd0, 32'd1);
                end else begin
                    e = q_rd.pop_front();
                    chk($sformatf("rd[%02h]", e.addr), {25'd0, char_code}, {25'd0, e.code});
                end
            end
            if (pend_acc) begin
                if (q_cur.size() == 0) begin
                    chk("cur_queue_empty", 32'd0, 32'd1);
                end else begin
                    ec = q_cur.pop_front();
                    chk("cursor_xy", {24'd0, cursor_xy}, {24'd0, ec});
                end
            end
            pend_rd  = rd_req && rst_n;
            pend_acc = in_valid && in_ready && rst_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte, hold in_valid until accepted; reports how many edges it stalled
    task automatic send_w(input logic [7:0] b, input logic [7:0] exp_cur, output int waits);
        logic rdy;
        in_valid = 1'b1;
        in_char  = b;
        q_cur.push_back(exp_cur);
        model_cur = exp_cur;
        waits = 0;
        forever begin
            rdy = in_ready;
            tick();
            if (rdy) break;
            waits++;
            if (waits > 1000) begin
                chk("accept_timeout", 32'd0, 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic [7:0] exp_cur);
        int w;
        send_w(b, exp_cur, w);
    endtask

    task automatic rd(input logic [7:0] a, input logic [6:0] e);
`ifdef CHAR_BUF_CURSOR_EN
        if (a == model_cur) return;   // overlay may cover the cursor cell
`endif
        rd_req  = 1'b1;
        char_xy = a;
        q_rd.push_back('{a, e});
        tick();
        rd_req = 1'b0;
    endtask

    // Count edges until in_ready rises after a reset/clear
    task automatic count_clear(input string nm);
        int n;
        n = 0;
        while (!in_ready && n < 400) begin
            tick();
            n++;
        end
        chk(nm, n, 256);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_cursor"}, {24'd0, cursor_xy}, 32'd0);
    endtask

    initial begin : stim
        int w;
        logic [7:0] b;
`ifdef CHAR_BUF_CURSOR_EN
        logic [6:0] s [16];
`endif
        // Reset state
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_cursor", {24'd0, cursor_xy}, 32'd0);
        chk("rst_char_code", {25'd0, char_code}, 32'd0);
        rst_n = 1'b1;
        count_clear("clear_len");
        for (int a = 0; a < 256; a++) rd(8'(a), 7'h20);

        // "One" from cursor 0
        send(8'h4F, 8'h01); send(8'h6E, 8'h02); send(8'h65, 8'h03);
        rd(8'h00, 7'h4F); rd(8'h01, 7'h6E); rd(8'h02, 7'h65); rd(8'h03, 7'h20);

        // Move to 8'h13, then CR and LF
        send(8'h0A, 8'h10);
        send(8'h78, 8'h11); send(8'h79, 8'h12); send(8'h7A, 8'h13);
        send(8'h0D, 8'h10); send(8'h0A, 8'h20);
        rd(8'h10, 7'h78); rd(8'h12, 7'h7A);
        for (int k = 3; k < 16; k++) send(8'h0A, {4'(k), 4'h0});
        send(8'h0A, 8'h00);   // row 15 wraps to row 0

        // Backspace mid-row, discarded bytes, printable boundaries
        send(8'h61, 8'h01); send(8'h62, 8'h02); send(8'h63, 8'h03);
        send(8'h64, 8'h04); send(8'h65, 8'h05);
        send(8'h08, 8'h04);
        rd(8'h04, 7'h20); rd(8'h03, 7'h64);
        send(8'h80, 8'h04); send(8'h07, 8'h04); send(8'hE1, 8'h04); send(8'h7F, 8'h04);
        rd(8'h04, 7'h20);
        send(8'h7E, 8'h05); send(8'h20, 8'h06);
        rd(8'h04, 7'h7E);
        send(8'h0A, 8'h10); send(8'h0A, 8'h20); send(8'h0A, 8'h30);
        send(8'h08, 8'h30);   // column 0: no effect

        // Form feed with next byte held valid
        send(8'h0C, 8'h00);
        send_w(8'h51, 8'h01, w);
        chk("ff_stall", w, 256);
        rd(8'h00, 7'h51);
        for (int a = 1; a < 256; a++) rd(8'(a), 7'h20);

`ifdef CHAR_BUF_CURSOR_EN
        // Blink overlay at cursor 8'h01 (stored space), period 4 cycles per phase
        char_xy = 8'h01;
        tick(); tick();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            s[i] = char_code;
        end
        for (int i = 0; i < 16; i++)
            chk("blink_val", {31'd0, (s[i] == 7'h5F) || (s[i] == 7'h20)}, 32'd1);
        for (int i = 0; i < 12; i++)
            chk("blink_alt", {31'd0, s[i] != s[i+4]}, 32'd1);
        tick();
`endif

        // 257 printables from cursor 0: cursor wraps and mem[0] holds the last one
        send(8'h0C, 8'h00);
        for (int i = 0; i < 257; i++) begin
            b = 8'h21 + 8'(i % 94);
            send(b, 8'(i + 1));
        end
        rd(8'h00, 7'h65); rd(8'h01, 7'h22); rd(8'h80, 7'h43); rd(8'hFF, 7'h64);

        // Reset pulse in the middle of a form-feed clear restarts the full count
        send(8'h0C, 8'h00);
        repeat (100) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_busy", {31'd0, busy}, 32'd1);
        chk("midrst_cursor", {24'd0, cursor_xy}, 32'd0);
        chk("midrst_char_code", {25'd0, char_code}, 32'd0);
        rst_n = 1'b1;
        count_clear("midrst_clear_len");
        send(8'h5A, 8'h01);
        rd(8'h00, 7'h5A); rd(8'h01, 7'h20);

        repeat (3) tick();
        chk("rd_queue_drained", q_rd.size(), 0);
        chk("cur_queue_drained", q_cur.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
